// File: rtl/imem_arbiter.sv
// imem_arbiter: two-master round-robin arbiter in front of the single
// synchronous program-memory port. Master 0 is core instruction fetch
// (read-only), master 1 is the loader/debug port, which may lock the port
// for bursts. Accept at edge T -> memory command in cycle T+1 -> read data
// and rvalid to the issuing master in cycle T+2.
module imem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,

    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    input  logic              m1_lock_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m1_rdata_o,

    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_e;

    // Master identifiers used by the round-robin pointer and pending tag
    localparam logic ID_M0 = 1'b0;
    localparam logic ID_M1 = 1'b1;

    lock_state_e       state_q, state_d;
    logic              last_q, last_d;

    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic              pend_vld_q, pend_vld_d;
    logic              pend_id_q, pend_id_d;
    logic              m0_rvalid_q, m0_rvalid_d;
    logic              m1_rvalid_q, m1_rvalid_d;

    logic              m0_gnt_c;
    logic              m1_gnt_c;
    logic              m0_acc_c;
    logic              m1_acc_c;

    // Grants, lock FSM next state and round-robin pointer update
    always_comb begin
        m0_gnt_c = 1'b0;
        m1_gnt_c = 1'b0;
        m0_acc_c = 1'b0;
        m1_acc_c = 1'b0;
        state_d  = state_q;
        last_d   = last_q;

        if (rst) begin
            if (state_q == ST_LOCKED) begin
                // Loader owns the port; fetch is stalled
                m1_gnt_c = m1_req_i;
            end else if (m0_req_i && m1_req_i) begin
                // Tie goes to whichever master was not granted last
                if (last_q == ID_M1) begin
                    m0_gnt_c = 1'b1;
                end else begin
                    m1_gnt_c = 1'b1;
                end
            end else begin
                m0_gnt_c = m0_req_i;
                m1_gnt_c = m1_req_i;
            end
        end

        m0_acc_c = m0_req_i & m0_gnt_c;
        m1_acc_c = m1_req_i & m1_gnt_c;

        if (m0_acc_c) begin
            last_d = ID_M0;
        end else if (m1_acc_c) begin
            last_d = ID_M1;
        end

        case (state_q)
            ST_UNLOCKED: begin
                if (m1_acc_c && m1_lock_i) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                // Release takes effect from the next cycle
                if (!m1_lock_i) begin
                    state_d = ST_UNLOCKED;
                end
            end
            default: begin
                state_d = ST_UNLOCKED;
            end
        endcase
    end

    // Memory command for the accepted master; addr/wdata hold when idle
    always_comb begin
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        if (m0_acc_c) begin
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = m0_addr_i;
            mem_wdata_d = DATA_W'(0);
        end else if (m1_acc_c) begin
            mem_en_d    = 1'b1;
            mem_we_d    = m1_we_i;
            mem_addr_d  = m1_addr_i;
            mem_wdata_d = m1_wdata_i;
        end
    end

    // Pending read tag travels with the command, then becomes rvalid
    always_comb begin
        pend_vld_d  = 1'b0;
        pend_id_d   = pend_id_q;
        m0_rvalid_d = 1'b0;
        m1_rvalid_d = 1'b0;

        if (m0_acc_c) begin
            pend_vld_d = 1'b1;
            pend_id_d  = ID_M0;
        end else if (m1_acc_c) begin
            pend_vld_d = ~m1_we_i;
            pend_id_d  = ID_M1;
        end

        m0_rvalid_d = pend_vld_q & (pend_id_q == ID_M0);
        m1_rvalid_d = pend_vld_q & (pend_id_q == ID_M1);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_UNLOCKED;
            last_q      <= ID_M1;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= ADDR_W'(0);
            mem_wdata_q <= DATA_W'(0);
            pend_vld_q  <= 1'b0;
            pend_id_q   <= ID_M0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            pend_vld_q  <= pend_vld_d;
            pend_id_q   <= pend_id_d;
            m0_rvalid_q <= m0_rvalid_d;
            m1_rvalid_q <= m1_rvalid_d;
        end
    end

    assign m0_gnt_o    = m0_gnt_c;
    assign m1_gnt_o    = m1_gnt_c;
    assign m0_rvalid_o = m0_rvalid_q;
    assign m1_rvalid_o = m1_rvalid_q;
    assign m0_rdata_o  = mem_rdata_i;
    assign m1_rdata_o  = mem_rdata_i;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Two-master arbiter sharing the single synchronous program-memory port between the `open_risc_v` instruction fetch (master 0) and a program loader/debug port (master 1). It sits in the SoC between the core's fetch interface, the loader, and the program memory. It accepts at most one access per cycle, registers the memory command, and routes returned read data back to the issuing master with a fixed 2-cycle accept-to-data latency. Master 1 can lock the port for bursts, which stalls core fetch.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width

- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-low reset
- `m0_req_i`  in  1  core fetch request; address held stable until granted
- `m0_addr_i`  in  ADDR_W  core fetch address (read-only master)
- `m0_gnt_o`  out  1  combinational grant; request accepted at the clock edge where `req&gnt`
- `m0_rvalid_o`  out  1  read data valid for master 0
- `m0_rdata_o`  out  DATA_W  read data, equal to `mem_rdata_i`
- `m1_req_i`  in  1  loader request
- `m1_we_i`  in  1  1 = write, 0 = read
- `m1_addr_i`  in  ADDR_W  loader address
- `m1_wdata_i`  in  DATA_W  loader write data
- `m1_lock_i`  in  1  burst lock request
- `m1_gnt_o`  out  1  combinational grant
- `m1_rvalid_o`  out  1  read data valid for master 1; never asserted for writes
- `m1_rdata_o`  out  DATA_W  read data, equal to `mem_rdata_i`
- `mem_en_o`  out  1  registered memory enable
- `mem_we_o`  out  1  registered write enable
- `mem_addr_o`  out  ADDR_W  registered address
- `mem_wdata_o`  out  DATA_W  registered write data
- `mem_rdata_i`  in  DATA_W  memory read data, valid the cycle after `mem_en_o & ~mem_we_o`

## Operation
- Grant logic is combinational from `req`, the `last` pointer, and `locked`. At most one `gnt` is high per cycle. No grant is asserted while `rst = 0`.
- Round-robin arbitration:
  - Only one master requesting: that master is granted.
  - Both requesting: grant goes to the master not equal to `last`.
  - `last` updates to the granted master on every accept.
  - Reset value of `last` is 1, so master 0 wins the first tie.
- Lock state machine, states UNLOCKED and LOCKED:
  - UNLOCKED -> LOCKED on an accepted m1 access with `m1_lock_i = 1`.
  - LOCKED -> UNLOCKED when `m1_lock_i = 0`, sampled at any edge. The `m0` grant re-enables in the following cycle.
  - In LOCKED, `m0_gnt_o = 0` regardless of requests. `m1` is granted whenever it requests.
  - Reset state is UNLOCKED.
- Accept at edge T: at T+1 the mem command registers load the accepted master's `addr`, `we` (forced 0 for m0), and `wdata` (0 for m0), and `mem_en_o = 1`. With no accept, `mem_en_o` and `mem_we_o` return to 0 while addr/wdata hold their values.
- Issue tracking: a 1-bit pending tag (`vld`, `id`) advances with the command. `mN_rvalid_o` is high in the cycle after a read is issued to memory, for the issuing master only.
- `m0_rdata_o` and `m1_rdata_o` are wired to `mem_rdata_i`. Masters qualify the data with their own `rvalid`.
- Back-to-back: an accept is allowed every cycle, giving full throughput. Read data returns in issue order, one per cycle.

## Timing
- Reset values of all registered outputs: `mem_en_o`, `mem_we_o`, `mem_addr_o`, `mem_wdata_o`, `m0_rvalid_o`, `m1_rvalid_o` are 0.
- Latency: accept edge T -> `mem_en_o` high in cycle T+1 -> `rvalid` and data in cycle T+2.
- Requester rules:
  - `req`, `addr`, `we`, and `wdata` stay stable while `req = 1` and `gnt = 0`.
  - The requester may drop or change them in the cycle after an accepting edge.
- Simultaneous events:
  - Both masters request in the same cycle that lock is released: round-robin applies from the next cycle.
  - A write with `m1_lock_i = 1` still enters LOCKED.
- Reset mid-operation: pending tags are cleared, so no `rvalid` is issued for in-flight reads. Memory outputs go to 0 at the reset edge.

## Test plan
- Core-only fetch: m0 requests addresses 0x0, 0x4, 0x8 continuously -> `m0_gnt_o` is high in all 3 cycles, `mem_addr_o` = 0x0/0x4/0x8 in cycles 1–3, `m0_rvalid_o` high in cycles 2–4 with ROM words in order.
- Tie round-robin: both masters request continuously from reset, m1 reading 0x100 -> grant sequence m0, m1, m0, m1. The `rvalid` sequence matches this order, shifted by 2 cycles.
- Loader write: m1 requests `we = 1`, `addr = 0x20`, `wdata = 0xDEADBEEF` -> next cycle `mem_we_o = 1`, `mem_addr_o = 0x20`, `mem_wdata_o = 0xDEADBEEF`. No `m1_rvalid_o`.
- Lock burst: m1 performs 4 locked writes while m0 requests continuously -> `m0_gnt_o = 0` for the whole burst. `m0_gnt_o` rises in the cycle after `m1_lock_i` falls.
- Reset mid-read: m0 read accepted at edge T, `rst = 0` at edge T+1 -> `mem_en_o = 0` and no `m0_rvalid_o` at T+2. The first tie after reset is granted to m0.
